// File: rtl/key_step_conditioner.sv
// Synchronises and debounces a raw data switch and an active-low push-button for single-stepping an FSM.
// Optional auto-repeat while the button is held is enabled by defining KSC_AUTO_REPEAT_EN.
module key_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int REP_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    input  logic sw,
    output logic data,
    output logic step,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state, state_d;
    logic             btn_s1, btn_s2, sw_s1, sw_s2;
    logic [CNT_W-1:0] sw_cnt, btn_cnt, btn_cnt_d;
    logic             step_d;
    logic             vld1, vld2, armed;
    logic             p;

    assign p    = ~btn_s2;
    assign held = (state == HELD) || (state == RELEASE_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            sw_s1  <= 1'b0;
            sw_s2  <= 1'b0;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data   <= 1'b0;
            sw_cnt <= '0;
        end else if (sw_s2 == data) begin
            sw_cnt <= '0;
        end else if (sw_cnt == CNT_MAX) begin
            data   <= sw_s2;
            sw_cnt <= '0;
        end else begin
            sw_cnt <= sw_cnt + 1'b1;
        end
    end

    // A press is only allowed to step once the synchroniser has flushed and the
    // button has been seen released in IDLE, so a button held through reset never steps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld1  <= 1'b0;
            vld2  <= 1'b0;
            armed <= 1'b0;
        end else begin
            vld1  <= 1'b1;
            vld2  <= vld1;
            armed <= armed | (vld2 & (state == IDLE) & ~p);
        end
    end

`ifdef KSC_AUTO_REPEAT_EN
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt, rep_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rep_cnt <= '0;
        else      rep_cnt <= rep_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            btn_cnt <= '0;
            step    <= 1'b0;
        end else begin
            state   <= state_d;
            btn_cnt <= btn_cnt_d;
            step    <= step_d;
        end
    end

    always_comb begin
        state_d   = state;
        btn_cnt_d = btn_cnt;
        step_d    = 1'b0;
`ifdef KSC_AUTO_REPEAT_EN
        rep_cnt_d = '0;
`endif
        case (state)
            IDLE: begin
                if (p) begin
                    state_d   = PRESS_WAIT;
                    btn_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_d   = IDLE;
                    btn_cnt_d = '0;
                end else if (btn_cnt == CNT_MAX) begin
                    state_d   = HELD;
                    btn_cnt_d = '0;
                    step_d    = armed;
                end else begin
                    btn_cnt_d = btn_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!p) begin
                    state_d   = RELEASE_WAIT;
                    btn_cnt_d = '0;
                end
`ifdef KSC_AUTO_REPEAT_EN
                else if (rep_cnt == REP_MAX) begin
                    step_d = armed;
                end else begin
                    rep_cnt_d = rep_cnt + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                // Bounce back to pressed resumes HELD without re-arming a step.
                if (p) begin
                    state_d   = HELD;
                    btn_cnt_d = '0;
                end else if (btn_cnt == CNT_MAX) begin
                    state_d   = IDLE;
                    btn_cnt_d = '0;
                end else begin
                    btn_cnt_d = btn_cnt + 1'b1;
                end
            end
        endcase
    end

endmodule
